// File: rtl/montgomery_mult_sequencer_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier sequencer and its PE row.
// Holds the FSM state encoding and the default operand width.
package montgomery_mult_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mmm_pe_row.sv
// Combinational row of mux-based processing elements: one radix-2 Montgomery step.
// Produces the quotient bit q and (R + addend) >> 1 at full WIDTH+2 precision.
module mmm_pe_row #(
    parameter int WIDTH = 8
) (
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH+1:0] r,
    output logic             q,
    output logic [WIDTH+1:0] r_next
);

    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] bm_sum;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    assign b_ext  = {2'b00, b};
    assign m_ext  = {2'b00, m};
    assign bm_sum = b_ext + m_ext;

    // q forces the sum even so the shift below is an exact division by two.
    assign q = r[0] ^ (a_bit & b[0]);

    for (genvar gi = 0; gi < WIDTH + 2; gi++) begin : g_pe
        assign addend[gi] = a_bit ? (q ? bm_sum[gi] : b_ext[gi])
                                  : (q ? m_ext[gi]  : 1'b0);
    end

    // R < 2M keeps R + B + M below 4M, so WIDTH+2 bits hold the sum.
    assign sum    = r + addend;
    assign r_next = sum >> 1;

endmodule

// File: rtl/montgomery_mult_sequencer.sv
// Sequencer for a bit-serial radix-2 Montgomery multiplier: R = A*B*2^(-WIDTH) mod M.
// Owns operand capture, the iteration counter, the FSM and the final conditional subtraction.
module montgomery_mult_sequencer
    import montgomery_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] r_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH+1:0] acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             err_reg, err_next;

    logic             pe_q;
    logic [WIDTH+1:0] pe_r;

    mmm_pe_row #(
        .WIDTH (WIDTH)
    ) u_pe_row (
        .a_bit  (a_reg[0]),
        .b      (b_reg),
        .m      (m_reg),
        .r      (acc_reg),
        .q      (pe_q),
        .r_next (pe_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            m_reg     <= '0;
            r_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            m_reg     <= m_next;
            r_reg     <= r_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        m_next     = m_reg;
        r_next     = r_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    a_next   = a_i;
                    b_next   = b_i;
                    m_next   = m_i;
                    acc_next = '0;
                    cnt_next = '0;
                    if (!m_i[0]) begin
                        err_next   = 1'b1;
                        r_next     = '0;
                        state_next = DONE;
                    end else begin
                        state_next = ITER;
                    end
                end
            end
            ITER: begin
                // Consumed A bits shift out; the vacated top collects the quotient digits.
                acc_next = pe_r;
                a_next   = {pe_q, a_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = SUB;
                end
            end
            SUB: begin
                if (acc_reg >= {2'b00, m_reg}) begin
                    r_next = acc_reg[WIDTH-1:0] - m_reg;
                end else begin
                    r_next = acc_reg[WIDTH-1:0];
                end
                err_next   = 1'b0;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o = (state_reg == ITER) || (state_reg == SUB);
    assign done_o = (state_reg == DONE);
    assign err_o  = err_reg;
    assign r_o    = r_reg;

endmodule
